display_out_fifo: RTL
=====================

// Module: display_out_fifo
// PURPOSE
//   CPU-side display port (DSP 0xD012 / DSPCR 0xD013) with a character FIFO and real busy flow control.
//   Replaces the hardwired "always ready" display status, so DSP bit7 reflects actual backpressure.
//   Sits between the 6502 data/address bus and the display terminal renderer.
//   Drains chars to the renderer over a valid/ready stream, optionally paced to original terminal speed.
// PARAMETERS
//   DEPTH        16   FIFO entries; power of two, 2..16
//   PACE_CYCLES  0    minimum clk7 cycles between renderer pops; 0 = unpaced
// PORTS
//   clk7        in   1  7 MHz master clock; single clock domain
//   reset       in   1  synchronous, active-high reset
//   cpu_clken   in   1  CPU clock enable; bus accesses qualify only when high
//   cs          in   1  display chip select (addr[15:1] == 0xD012>>1)
//   address     in   1  addr[0]: 0 = DSP, 1 = DSPCR
//   we          in   1  CPU write strobe
//   din         in   8  CPU write data
//   dout        out  8  read data to CPU data-in mux (combinational from registers)
//   char_valid  out  1  FIFO head valid toward renderer
//   char_data   out  7  FIFO head character (ASCII, bit7 stripped)
//   char_ready  in   1  renderer accepts head this cycle
//   cls         in   1  clear-screen request, level; flushes FIFO
// BEHAVIOUR
//   Bus write: fires on cs & we & cpu_clken (one push per qualified cycle).
//   - addr 0, not full: push din[6:0]; last_char <= din[6:0].
//   - addr 0, full: drop char; set ovf (sticky); last_char unchanged.
//   - addr 1: din[7]=1 clears ovf; all other bits ignored.
//   Bus read (combinational, no side effects):
//   - addr 0: {busy, last_char}; busy = full | pace_hold.
//   - addr 1: {ovf, 2'b0, count[4:0]}.
//   Full/empty come from the registered count (value at start of cycle).
//   - Push while full with a same-cycle pop: push rejected, ovf set.
//   - No bypass: a char written at edge N gives char_valid=1 after edge N (visible cycle N+1) if FIFO was empty.
//   Pop: char_valid & char_ready & !pace_hold.
//   - char_valid = !empty & !pace_hold; char_data = head entry.
//   Pacer:
//   - On each pop, pace_cnt <= PACE_CYCLES-1; pace_hold = (pace_cnt != 0); decrements every clk7.
//   - With PACE_CYCLES=0, pace_hold is constant 0.
//   Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
//   Pointer wrap: modulo DEPTH; count is $clog2(DEPTH)+1 bits; DEPTH=16 gives count 0..16.
//   cls=1: each cycle, rd_ptr<=wr_ptr, count<=0, pace_cnt<=0; pushes are dropped and ovf is not set.
//   - ovf and last_char are kept.
//   reset (sync, overrides everything) clears:
//   - count, pointers, pace_cnt, ovf
//   - last_char=7'h00
//   Reset values: char_valid=0, char_data=7'h00 (head of a cleared RAM reads as don't-care, forced 0 when empty),
//   dout = 8'h00 for addr 0 and for addr 1.
//   Reset mid-stream: any pending chars are discarded; no partial pop is emitted.
// STRUCTURE
//   Shared include apple1_defs.vh holds ADDR_DSP=16'hD012, ADDR_DSPCR=16'hD013,
//   and DSPCR bit indices (OVF=7, COUNT=4:0).
//   One sub-module: sync_fifo
//   - params WIDTH=7, DEPTH; ports clk7, reset, flush, push, pop, wdata, rdata, count, full, empty
//   - register-array storage, reads head combinationally.
//   The top level holds bus decode, last_char/ovf registers, the pacer counter and the dout mux.
// TESTING
//   1. Reset, then read DSP and DSPCR -> 8'h00 / 8'h00; char_valid=0.
//   2. Write 0xC1 to DSP, char_ready=1, PACE_CYCLES=0 -> char_valid high next cycle,
//      char_data=7'h41, popped; DSPCR count returns to 0.
//   3. char_ready=0, DEPTH=16, write 17 chars -> DSP bit7=1 after the 16th; 17th dropped; DSPCR=8'h90.
//      Write DSPCR 0x80 -> DSPCR=8'h10.
//   4. PACE_CYCLES=8, queue 3 chars, char_ready=1 -> pops spaced exactly 8 clk7 apart; DSP bit7=1 during the hold.
//   5. Queue 5 chars, assert cls 1 cycle -> count=0, char_valid=0; write during cls dropped without ovf;
//      last_char is retained.
//   6. Full FIFO with a simultaneous pop and push -> push rejected, ovf=1, count=15;
//      assert reset mid-stream -> all state cleared on the next edge.

Source files
------------

// File: rtl/display_out_fifo_pkg.sv
// Shared definitions for the CPU-side display port.
// Bus addresses, DSPCR bit positions and register select encoding.
package display_out_fifo_pkg;

    localparam logic [15:0] ADDR_DSP   = 16'hD012;
    localparam logic [15:0] ADDR_DSPCR = 16'hD013;

    localparam int DSP_BUSY     = 7;
    localparam int DSPCR_OVF    = 7;
    localparam int DSPCR_CNT_HI = 4;
    localparam int DSPCR_CNT_LO = 0;

    typedef enum logic {
        REG_DSP   = 1'b0,
        REG_DSPCR = 1'b1
    } reg_sel_e;

endpackage

// File: rtl/display_out_fifo_sync_fifo.sv
// Single-clock register-array FIFO with flush; head is read combinationally.
// Ports: clk7/reset, flush, push/wdata, pop/rdata, count, full, empty.
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 16
) (
    input  logic                     clk7,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk7) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push & ~do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop & ~do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk7) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/display_out_fifo.sv
// Display port DSP/DSPCR with character FIFO, sticky overflow and optional pacing.
// Ports: 6502 bus (cs/address/we/din/dout), renderer stream (char_*), cls flush.
module display_out_fifo
    import display_out_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PACE_CYCLES = 0
) (
    input  logic       clk7,
    input  logic       reset,
    input  logic       cpu_clken,
    input  logic       cs,
    input  logic       address,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       char_valid,
    output logic [6:0] char_data,
    input  logic       char_ready,
    input  logic       cls
);

    localparam int CW = $clog2(DEPTH) + 1;

    reg_sel_e      sel;
    logic          bus_wr;
    logic          dsp_wr;
    logic          cr_wr;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          pace_hold;
    logic [6:0]    head;
    logic [CW-1:0] count;
    logic [4:0]    count5;

    logic [6:0]    last_char_q, last_char_d;
    logic          ovf_q, ovf_d;

    assign sel    = reg_sel_e'(address);
    assign bus_wr = cs & we & cpu_clken;
    assign dsp_wr = bus_wr & (sel == REG_DSP);
    assign cr_wr  = bus_wr & (sel == REG_DSPCR);

    // A flush swallows writes without flagging them as overflow.
    assign push = dsp_wr & ~full & ~cls;
    assign drop = dsp_wr & full & ~cls;

    assign char_valid = ~empty & ~pace_hold;
    assign char_data  = empty ? 7'h00 : head;
    assign pop        = char_valid & char_ready;

    sync_fifo #(
        .WIDTH (7),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk7  (clk7),
        .reset (reset),
        .flush (cls),
        .push  (push),
        .pop   (pop),
        .wdata (din[6:0]),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    if (PACE_CYCLES == 0) begin : g_nopace
        assign pace_hold = 1'b0;
    end else begin : g_pace
        localparam int PW = $clog2(PACE_CYCLES + 1);

        logic [PW-1:0] pace_cnt_q, pace_cnt_d;

        // Loading PACE_CYCLES-1 on a pop spaces pops exactly PACE_CYCLES apart.
        always_comb begin
            pace_cnt_d = pace_cnt_q;
            if (cls)                    pace_cnt_d = '0;
            else if (pop)               pace_cnt_d = PW'(PACE_CYCLES - 1);
            else if (pace_cnt_q != '0)  pace_cnt_d = pace_cnt_q - 1'b1;
        end

        always_ff @(posedge clk7) begin
            if (reset) pace_cnt_q <= '0;
            else       pace_cnt_q <= pace_cnt_d;
        end

        assign pace_hold = (pace_cnt_q != '0);
    end

    always_comb begin
        last_char_d = last_char_q;
        ovf_d       = ovf_q;
        if (push)                  last_char_d = din[6:0];
        if (drop)                  ovf_d = 1'b1;
        else if (cr_wr && din[7])  ovf_d = 1'b0;
    end

    always_ff @(posedge clk7) begin
        if (reset) begin
            last_char_q <= 7'h00;
            ovf_q       <= 1'b0;
        end else begin
            last_char_q <= last_char_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy   = full | pace_hold;
    assign count5 = 5'(count);

    always_comb begin
        dout = 8'h00;
        unique case (sel)
            REG_DSP:   dout = {busy, last_char_q};
            REG_DSPCR: dout = {ovf_q, 2'b00, count5};
            default:   dout = 8'h00;
        endcase
    end

endmodule
